// File: rtl/clarvi_wb_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clarvi_wb_sequencer_pkg
//  Purpose  : Shared types for the writeback sequencer. Defines the writeback
//             mode, the buffered entry layout, the head FSM state encoding and
//             a helper that picks the first beat of an entry.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package clarvi_wb_sequencer_pkg;

    localparam int C_DEPTH  = 2;
    localparam int C_REG_W  = 5;
    localparam int C_DATA_W = 64;
    localparam int C_HALF_W = 32;

    // 2'b11 is illegal; everything that is not LO or HI behaves as FULL.
    typedef enum logic [1:0] {
        WB_LO   = 2'b00,
        WB_HI   = 2'b01,
        WB_FULL = 2'b10
    } wb_mode_t;

    typedef struct packed {
        logic [C_REG_W-1:0]  rd;
        wb_mode_t            mode;
        logic [C_DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_BEAT_LO = 2'b01,
        ST_BEAT_HI = 2'b10
    } wb_state_t;

    // High-only entries skip straight to the high beat.
    function automatic wb_state_t first_beat(input wb_mode_t mode);
        return (mode == WB_HI) ? ST_BEAT_HI : ST_BEAT_LO;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clarvi_wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : clarvi_wb_fifo
//  Purpose  : Two-entry circular buffer of writeback entries.
//  Ports    : clock, reset_n (sync, active-low)
//             push/push_entry  - write a new entry at the tail
//             pop              - retire the head entry
//             head, second     - oldest and next-oldest entries
//             entry_rd, valid  - per-slot destination view for hazard checks
//             count            - occupancy 0..2
//  Revision : 1.0  initial release
// ============================================================================
module clarvi_wb_fifo
    import clarvi_wb_sequencer_pkg::*;
(
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              push,
    input  wb_entry_t                         push_entry,
    input  logic                              pop,
    output wb_entry_t                         head,
    output wb_entry_t                         second,
    output logic [C_DEPTH-1:0][C_REG_W-1:0]   entry_rd,
    output logic [C_DEPTH-1:0]                valid,
    output logic [1:0]                        count
);

    wb_entry_t [C_DEPTH-1:0] r_entries_q, w_entries_d;
    logic                    r_rd_ptr_q,  w_rd_ptr_d;
    logic                    r_wr_ptr_q,  w_wr_ptr_d;
    logic [1:0]              r_count_q,   w_count_d;

    always_comb begin
        w_entries_d = r_entries_q;
        w_rd_ptr_d  = r_rd_ptr_q;
        w_wr_ptr_d  = r_wr_ptr_q;
        w_count_d   = r_count_q;
        if (push) begin
            w_entries_d[r_wr_ptr_q] = push_entry;
            w_wr_ptr_d              = ~r_wr_ptr_q;
        end
        if (pop) begin
            w_rd_ptr_d = ~r_rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   w_count_d = r_count_q + 2'd1;
            2'b01:   w_count_d = r_count_q - 2'd1;
            default: w_count_d = r_count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_entries_q <= '0;
            r_rd_ptr_q  <= 1'b0;
            r_wr_ptr_q  <= 1'b0;
            r_count_q   <= 2'd0;
        end else begin
            r_entries_q <= w_entries_d;
            r_rd_ptr_q  <= w_rd_ptr_d;
            r_wr_ptr_q  <= w_wr_ptr_d;
            r_count_q   <= w_count_d;
        end
    end

    assign head   = r_entries_q[r_rd_ptr_q];
    assign second = r_entries_q[~r_rd_ptr_q];
    assign count  = r_count_q;

    // A slot is live when the buffer is full, or it is the head of a
    // single-entry buffer.
    for (genvar i = 0; i < C_DEPTH; i++) begin : g_view
        assign entry_rd[i] = r_entries_q[i].rd;
        assign valid[i]    = (r_count_q == 2'd2) ||
                             ((r_count_q == 2'd1) && (r_rd_ptr_q == 1'(i)));
    end

endmodule
`default_nettype wire

// File: rtl/clarvi_wb_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : clarvi_wb_sequencer
//  Purpose  : Splits 64-bit writeback results into ordered 32-bit register
//             file writes (low half before high half) and flags sources that
//             still have a buffered write pending.
//  Ports    : clock, reset_n (sync, active-low)
//             in_valid/in_ready/in_rd/in_mode/in_data - writeback request
//             write_enable/write_register/write_part/write_data - to RegFile
//             check_rs1/check_rs2 -> stall_rs1/stall_rs2 - decode hazards
//             busy - buffer non-empty
//  Revision : 1.0  initial release
// ============================================================================
module clarvi_wb_sequencer
    import clarvi_wb_sequencer_pkg::*;
(
    input  logic                clock,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [C_REG_W-1:0]  in_rd,
    input  wb_mode_t            in_mode,
    input  logic [C_DATA_W-1:0] in_data,
    output logic                write_enable,
    output logic [C_REG_W-1:0]  write_register,
    output logic                write_part,
    output logic [C_HALF_W-1:0] write_data,
    input  logic [C_REG_W-1:0]  check_rs1,
    input  logic [C_REG_W-1:0]  check_rs2,
    output logic                stall_rs1,
    output logic                stall_rs2,
    output logic                busy
);

    wb_entry_t                         w_in_entry;
    wb_entry_t                         w_head;
    wb_entry_t                         w_second;
    logic [C_DEPTH-1:0][C_REG_W-1:0]   w_entry_rd;
    logic [C_DEPTH-1:0]                w_valid;
    logic [1:0]                        w_count;
    logic                              w_push;
    logic                              w_pop;

    wb_state_t                 r_state_q, w_state_d;
    logic                      r_we_q,    w_we_d;
    logic [C_REG_W-1:0]        r_reg_q,   w_reg_d;
    logic                      r_part_q,  w_part_d;
    logic [C_HALF_W-1:0]       r_data_q,  w_data_d;
    logic [C_REG_W-1:0]        w_sel_rd;
    logic [C_DATA_W-1:0]       w_sel_data;

    assign w_in_entry = '{rd: in_rd, mode: in_mode, data: in_data};
    assign in_ready   = reset_n && (w_count != 2'd2);
    assign w_push     = in_valid && in_ready;

    // Pop is decided from registered state alone, keeping in_valid out of
    // the path to the write outputs.
    assign w_pop = (r_state_q == ST_BEAT_HI) ||
                   ((r_state_q == ST_BEAT_LO) && (w_head.mode == WB_LO));

    clarvi_wb_fifo u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (w_push),
        .push_entry (w_in_entry),
        .pop        (w_pop),
        .head       (w_head),
        .second     (w_second),
        .entry_rd   (w_entry_rd),
        .valid      (w_valid),
        .count      (w_count)
    );

    // Next-state and next-output: the entry driving the write outputs next
    // cycle is either the current head (LO->HI of a FULL entry), the entry
    // behind it after a pop, or the request being accepted right now.
    always_comb begin
        w_state_d  = r_state_q;
        w_sel_rd   = w_head.rd;
        w_sel_data = w_head.data;
        if ((r_state_q == ST_BEAT_LO) && !w_pop) begin
            w_state_d = ST_BEAT_HI;
        end else if (w_pop && (w_count == 2'd2)) begin
            w_state_d  = first_beat(w_second.mode);
            w_sel_rd   = w_second.rd;
            w_sel_data = w_second.data;
        end else if (w_push) begin
            w_state_d  = first_beat(in_mode);
            w_sel_rd   = in_rd;
            w_sel_data = in_data;
        end else begin
            w_state_d = ST_IDLE;
        end

        // rd == 0 keeps its beat slots but never writes.
        w_we_d   = (w_state_d != ST_IDLE) && (w_sel_rd != '0);
        w_reg_d  = (w_state_d != ST_IDLE) ? w_sel_rd : '0;
        w_part_d = (w_state_d == ST_BEAT_HI);
        case (w_state_d)
            ST_BEAT_LO: w_data_d = w_sel_data[C_HALF_W-1:0];
            ST_BEAT_HI: w_data_d = w_sel_data[C_DATA_W-1:C_HALF_W];
            default:    w_data_d = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state_q <= ST_IDLE;
            r_we_q    <= 1'b0;
            r_reg_q   <= '0;
            r_part_q  <= 1'b0;
            r_data_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_we_q    <= w_we_d;
            r_reg_q   <= w_reg_d;
            r_part_q  <= w_part_d;
            r_data_q  <= w_data_d;
        end
    end

    assign write_enable   = r_we_q;
    assign write_register = r_reg_q;
    assign write_part     = r_part_q;
    assign write_data     = r_data_q;

    // Only buffered entries count; the head being popped is still buffered
    // this cycle, the request being accepted is not yet.
    logic [C_DEPTH-1:0] w_hit_rs1, w_hit_rs2;
    for (genvar i = 0; i < C_DEPTH; i++) begin : g_hazard
        assign w_hit_rs1[i] = w_valid[i] && (w_entry_rd[i] != '0) &&
                              (w_entry_rd[i] == check_rs1);
        assign w_hit_rs2[i] = w_valid[i] && (w_entry_rd[i] != '0) &&
                              (w_entry_rd[i] == check_rs2);
    end

    assign stall_rs1 = |w_hit_rs1;
    assign stall_rs2 = |w_hit_rs2;
    assign busy      = (w_count != 2'd0);

endmodule
`default_nettype wire

// File: tb/tb_clarvi_wb_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clarvi_wb_sequencer
//  Purpose  : Scoreboard bench for clarvi_wb_sequencer. Requests push their
//             expected register-file beats into a queue; a negedge monitor
//             pops and compares every write the DUT presents.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_clarvi_wb_sequencer;
    import clarvi_wb_sequencer_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rd = '0;
    wb_mode_t    in_mode = WB_LO;
    logic [63:0] in_data = '0;
    logic        write_enable;
    logic [4:0]  write_register;
    logic        write_part;
    logic [31:0] write_data;
    logic [4:0]  check_rs1 = '0;
    logic [4:0]  check_rs2 = '0;
    logic        stall_rs1, stall_rs2, busy;

    clarvi_wb_sequencer dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_rd          (in_rd),
        .in_mode        (in_mode),
        .in_data        (in_data),
        .write_enable   (write_enable),
        .write_register (write_register),
        .write_part     (write_part),
        .write_data     (write_data),
        .check_rs1      (check_rs1),
        .check_rs2      (check_rs2),
        .stall_rs1      (stall_rs1),
        .stall_rs2      (stall_rs2),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  rd;
        logic        part;
        logic [31:0] data;
    } beat_t;

    beat_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] regs [32];
    int          cyc = 0;
    int          win_cnt = 0, win_first = 0, win_last = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every presented write is compared against the scoreboard and
    // applied to a reference register file that keeps the other half.
    always @(negedge clock) begin
        beat_t e;
        if (write_enable === 1'b1) begin
            if (win_cnt == 0) win_first = cyc;
            win_last = cyc;
            win_cnt++;
            if (write_part) regs[write_register][63:32] = write_data;
            else            regs[write_register][31:0]  = write_data;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected: actual rd=%0d part=%0d data=%h, required no write",
                         write_register, write_part, write_data);
            end else begin
                e = exp_q.pop_front();
                if (write_register !== e.rd || write_part !== e.part || write_data !== e.data) begin
                    errors++;
                    $display("FAIL beat_order: actual rd=%0d part=%0d data=%h, required rd=%0d part=%0d data=%h",
                             write_register, write_part, write_data, e.rd, e.part, e.data);
                end
            end
        end
    end

    task automatic push_expected(input logic [4:0] rd, input wb_mode_t mode, input logic [63:0] data);
        beat_t b;
        if (rd != 5'd0) begin
            if (mode != WB_HI) begin
                b.rd = rd; b.part = 1'b0; b.data = data[31:0];
                exp_q.push_back(b);
            end
            if (mode != WB_LO) begin
                b.rd = rd; b.part = 1'b1; b.data = data[63:32];
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Presents one request, waits (bounded) for in_ready, and returns #1
    // after the accepting edge.
    task automatic send(input logic [4:0] rd, input wb_mode_t mode, input logic [63:0] data,
                        output int waited);
        in_valid = 1'b1; in_rd = rd; in_mode = mode; in_data = data;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 20) begin
            @(posedge clock);
            #1;
            waited++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: actual in_ready=%b after %0d cycles, required 1", in_ready, waited);
        end else begin
            push_expected(rd, mode, data);
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic scen_full5(input string tag);
        int w;
        send(5'd5, WB_FULL, 64'h1122334455667788, w);
        chk({tag, "_n1_we"},   64'(write_enable), 64'd1);
        chk({tag, "_n1_part"}, 64'(write_part),   64'd0);
        chk({tag, "_n1_data"}, 64'(write_data),   64'h55667788);
        idle(1);
        chk({tag, "_n2_we"},   64'(write_enable), 64'd1);
        chk({tag, "_n2_part"}, 64'(write_part),   64'd1);
        chk({tag, "_n2_data"}, 64'(write_data),   64'h11223344);
        idle(1);
        chk({tag, "_n3_we"},   64'(write_enable), 64'd0);
        chk({tag, "_n3_busy"}, 64'(busy),         64'd0);
        chk({tag, "_x5"},      regs[5],           64'h1122334455667788);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        for (int i = 0; i < 32; i++) regs[i] = '0;

        // Reset state
        idle(2);
        chk("rst_we",     64'(write_enable),   64'd0);
        chk("rst_reg",    64'(write_register), 64'd0);
        chk("rst_part",   64'(write_part),     64'd0);
        chk("rst_data",   64'(write_data),     64'd0);
        chk("rst_ready",  64'(in_ready),       64'd0);
        chk("rst_stall1", 64'(stall_rs1),      64'd0);
        chk("rst_stall2", 64'(stall_rs2),      64'd0);
        chk("rst_busy",   64'(busy),           64'd0);
        reset_n = 1'b1;
        #1;
        chk("rel_ready", 64'(in_ready), 64'd1);

        // Single FULL write
        scen_full5("full");

        // Back-to-back low halves: never stalls, one write per cycle
        win_cnt = 0;
        for (int i = 1; i <= 4; i++) begin
            send(5'(i), WB_LO, {32'hFFFF_FFFF, 32'hA000_0000 | 32'(i)}, w);
            chk($sformatf("lo_ready_%0d", i), 64'(w), 64'd0);
        end
        idle(3);
        chk("lo_count", 64'(win_cnt), 64'd4);
        chk("lo_span",  64'(win_last - win_first), 64'd3);

        // Three FULL requests every cycle: third waits one cycle, six beats
        win_cnt = 0;
        send(5'd11, WB_FULL, 64'hA1A1A1A1_B1B1B1B1, w);
        chk("f3_wait1", 64'(w), 64'd0);
        send(5'd12, WB_FULL, 64'hA2A2A2A2_B2B2B2B2, w);
        chk("f3_wait2", 64'(w), 64'd0);
        send(5'd13, WB_FULL, 64'hA3A3A3A3_B3B3B3B3, w);
        chk("f3_wait3", 64'(w), 64'd1);
        idle(5);
        chk("f3_count", 64'(win_cnt), 64'd6);
        chk("f3_span",  64'(win_last - win_first), 64'd5);
        chk("f3_x12",   regs[12], 64'hA2A2A2A2_B2B2B2B2);

        // rd == 0: two silent beats, busy, no hazard
        win_cnt = 0;
        check_rs1 = 5'd0;
        send(5'd0, WB_FULL, 64'hCAFEBABE_DEADBEEF, w);
        chk("r0_b1_we",    64'(write_enable), 64'd0);
        chk("r0_b1_busy",  64'(busy),         64'd1);
        chk("r0_b1_stall", 64'(stall_rs1),    64'd0);
        idle(1);
        chk("r0_b2_we",    64'(write_enable), 64'd0);
        chk("r0_b2_busy",  64'(busy),         64'd1);
        chk("r0_b2_stall", 64'(stall_rs1),    64'd0);
        idle(1);
        chk("r0_done_busy", 64'(busy),    64'd0);
        chk("r0_writes",    64'(win_cnt), 64'd0);

        // Hazard on rs2 through both beats, clear after the pop
        check_rs2 = 5'd7;
        in_valid = 1'b1; in_rd = 5'd7; in_mode = WB_FULL; in_data = 64'h77777777_66666666;
        #1;
        chk("hz_accept_stall", 64'(stall_rs2), 64'd0);
        chk("hz_accept_ready", 64'(in_ready),  64'd1);
        push_expected(5'd7, WB_FULL, 64'h77777777_66666666);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        chk("hz_lo_stall", 64'(stall_rs2), 64'd1);
        idle(1);
        chk("hz_hi_stall", 64'(stall_rs2),  64'd1);
        chk("hz_hi_part",  64'(write_part), 64'd1);
        idle(1);
        chk("hz_after_stall", 64'(stall_rs2), 64'd0);
        check_rs2 = 5'd0;

        // Reset during the high beat of a two-entry backlog
        send(5'd9,  WB_FULL, 64'h99999999_88888888, w);
        send(5'd10, WB_FULL, 64'h10101010_20202020, w);
        chk("rs_hi_part", 64'(write_part),     64'd1);
        chk("rs_hi_reg",  64'(write_register), 64'd9);
        reset_n = 1'b0;
        #1;
        chk("rs_ready_low", 64'(in_ready), 64'd0);
        @(posedge clock);
        #1;
        chk("rs_we",       64'(write_enable), 64'd0);
        chk("rs_busy",     64'(busy),         64'd0);
        chk("rs_ready",    64'(in_ready),     64'd0);
        chk("rs_x9",       regs[9],           64'h99999999_88888888);
        chk("rs_dropped",  64'(exp_q.size()), 64'd2);
        exp_q.delete();
        reset_n = 1'b1;
        #1;
        chk("rs_rel_ready", 64'(in_ready), 64'd1);
        regs[5] = '0;
        scen_full5("post_rst");

        idle(3);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("final_x10_untouched", regs[10], 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
